// File: rtl/mem_access.sv
// Memory stage: passes non-memory ops through and sequences loads/stores as
// little-endian byte-serial transfers to the memory controller, stalling the pipe meanwhile.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [3:0]  mem_op_i,
    input  logic [4:0]  w_addr_i,
    input  logic        w_req_i,
    input  logic [31:0] w_data_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] st_data_i,
    output logic [4:0]  w_addr_o,
    output logic        w_req_o,
    output logic [31:0] w_data_o,
    output logic        stall_req_o,
    output logic        mc_req_o,
    output logic        mc_we_o,
    output logic [31:0] mc_addr_o,
    output logic [7:0]  mc_dout_o,
    input  logic [7:0]  mc_din_i,
    input  logic        mc_ack_i
);

    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLw  = 4'd3;
    localparam logic [3:0] OpLbu = 4'd4;
    localparam logic [3:0] OpLhu = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;

    logic        is_load, is_store, is_mem;
    logic [1:0]  last_cnt;
    logic [31:0] load_data;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        last_cnt = 2'd3;
        case (mem_op_i)
            OpLb, OpLbu: begin is_load  = 1'b1; last_cnt = 2'd0; end
            OpLh, OpLhu: begin is_load  = 1'b1; last_cnt = 2'd1; end
            OpLw:        begin is_load  = 1'b1; last_cnt = 2'd3; end
            OpSb:        begin is_store = 1'b1; last_cnt = 2'd0; end
            OpSh:        begin is_store = 1'b1; last_cnt = 2'd1; end
            OpSw:        begin is_store = 1'b1; last_cnt = 2'd3; end
            default:     last_cnt = 2'd3;
        endcase
        is_mem = is_load | is_store;
    end

    always_comb begin
        case (mem_op_i)
            OpLb:    load_data = {{24{buf_q[7]}}, buf_q[7:0]};
            OpLbu:   load_data = {24'd0, buf_q[7:0]};
            OpLh:    load_data = {{16{buf_q[15]}}, buf_q[15:0]};
            OpLhu:   load_data = {16'd0, buf_q[15:0]};
            default: load_data = buf_q;
        endcase
    end

    // rdy gates every state update, including reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                state_q <= StIdle;
                cnt_q   <= 2'd0;
                buf_q   <= 32'd0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                buf_q   <= buf_d;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        w_addr_o    = w_addr_i;
        w_req_o     = w_req_i;
        w_data_o    = w_data_i;
        stall_req_o = 1'b0;
        mc_req_o    = 1'b0;
        mc_we_o     = 1'b0;
        mc_addr_o   = 32'd0;
        mc_dout_o   = 8'd0;
        case (state_q)
            StIdle: begin
                if (is_mem) begin
                    stall_req_o = 1'b1;
                    w_req_o     = 1'b0;
                    state_d     = StAccess;
                    cnt_d       = 2'd0;
                end
            end
            StAccess: begin
                stall_req_o = 1'b1;
                w_req_o     = 1'b0;
                mc_req_o    = 1'b1;
                mc_we_o     = is_store;
                mc_addr_o   = mem_addr_i + {30'd0, cnt_q};
                if (is_store) begin
                    mc_dout_o = st_data_i[{cnt_q, 3'b000} +: 8];
                end
                if (mc_ack_i) begin
                    if (is_load) begin
                        buf_d[{cnt_q, 3'b000} +: 8] = mc_din_i;
                    end
                    if (cnt_q == last_cnt) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 2'd0;
                buf_d   = 32'd0;
                if (is_load) begin
                    w_data_o = load_data;
                end else if (is_store) begin
                    w_req_o  = 1'b0;
                    w_data_o = 32'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table vectors, hand-written corner sequences and
// randomized ops against a byte-array memory model with random ack/rdy.
module tb_mem_access;

    logic        clk, rst, rdy;
    logic [3:0]  mem_op_i;
    logic [4:0]  w_addr_i;
    logic        w_req_i;
    logic [31:0] w_data_i, mem_addr_i, st_data_i;
    logic [4:0]  w_addr_o;
    logic        w_req_o;
    logic [31:0] w_data_o;
    logic        stall_req_o, mc_req_o, mc_we_o;
    logic [31:0] mc_addr_o;
    logic [7:0]  mc_dout_o, mc_din_i;
    logic        mc_ack_i;

    logic [7:0]  mem [0:255];
    int          checks = 0;
    int          errors = 0;

    assign mc_din_i = mem[mc_addr_o[7:0]];

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .mem_op_i    (mem_op_i),
        .w_addr_i    (w_addr_i),
        .w_req_i     (w_req_i),
        .w_data_i    (w_data_i),
        .mem_addr_i  (mem_addr_i),
        .st_data_i   (st_data_i),
        .w_addr_o    (w_addr_o),
        .w_req_o     (w_req_o),
        .w_data_o    (w_data_o),
        .stall_req_o (stall_req_o),
        .mc_req_o    (mc_req_o),
        .mc_we_o     (mc_we_o),
        .mc_addr_o   (mc_addr_o),
        .mc_dout_o   (mc_dout_o),
        .mc_din_i    (mc_din_i),
        .mc_ack_i    (mc_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] w);
        case (op)
            4'd1:    return {{24{w[7]}}, w[7:0]};
            4'd4:    return {24'd0, w[7:0]};
            4'd2:    return {{16{w[15]}}, w[15:0]};
            4'd5:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] a, w;
        for (int i = 0; i < 4; i++) begin
            a = addr + i;
            w[8*i +: 8] = mem[a[7:0]];
        end
        return w;
    endfunction

    task automatic set_inputs(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] st, input logic [4:0] waddr,
                              input logic wreq, input logic [31:0] wdata);
        mem_op_i   = op;
        mem_addr_i = addr;
        st_data_i  = st;
        w_addr_i   = waddr;
        w_req_i    = wreq;
        w_data_i   = wdata;
    endtask

    task automatic do_nonmem(input logic [3:0] op, input logic [4:0] waddr,
                             input logic wreq, input logic [31:0] wdata);
        @(negedge clk);
        rst = 1'b0;
        rdy = ($urandom_range(3) != 0);
        mc_ack_i = 1'($urandom_range(1));
        set_inputs(op, $urandom, $urandom, waddr, wreq, wdata);
        #1;
        chk("pass_w_addr", {27'd0, w_addr_o}, {27'd0, waddr});
        chk("pass_w_req", {31'd0, w_req_o}, {31'd0, wreq});
        chk("pass_w_data", w_data_o, wdata);
        chk("pass_stall", {31'd0, stall_req_o}, 32'd0);
        chk("pass_mc_req", {31'd0, mc_req_o}, 32'd0);
    endtask

    // Drives one load/store from presentation through DONE, checking every cycle.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                         input logic [4:0] waddr, input logic wreq, input logic [31:0] wdata,
                         input int ack_pct, input int rdy_pct, input int hold0,
                         input int gap_at, output logic [31:0] got_data, output int cycles);
        int n, k, phase, held, gap;
        bit done, is_store;
        logic [31:0] exp_w, a, s;
        n        = nbytes(op);
        is_store = (op >= 4'd6);
        exp_w    = is_store ? 32'd0 : ref_load(op, mem_word(addr));
        k = 0; phase = 0; held = 0; gap = 0; done = 0; cycles = 0; got_data = 'x;
        while (!done && cycles < 300) begin
            @(negedge clk);
            rst = 1'b0;
            set_inputs(op, addr, st, waddr, wreq, wdata);
            if (phase == 1 && k == gap_at && gap < 2) begin
                rdy = 1'b0;
                gap++;
            end else begin
                rdy = ($urandom_range(99) < rdy_pct);
            end
            if (phase == 1 && k == 0 && held < hold0) begin
                mc_ack_i = 1'b0;
                held++;
            end else if (phase == 1) begin
                mc_ack_i = ($urandom_range(99) < ack_pct);
            end else begin
                mc_ack_i = 1'($urandom_range(1));
            end
            #1;
            cycles++;
            case (phase)
                0: begin
                    chk("idle_stall", {31'd0, stall_req_o}, 32'd1);
                    chk("idle_mc_req", {31'd0, mc_req_o}, 32'd0);
                    if (rdy) phase = 1;
                end
                1: begin
                    a = addr + k;
                    chk("acc_stall", {31'd0, stall_req_o}, 32'd1);
                    chk("acc_mc_req", {31'd0, mc_req_o}, 32'd1);
                    chk("acc_mc_we", {31'd0, mc_we_o}, {31'd0, is_store});
                    chk("acc_mc_addr", mc_addr_o, a);
                    if (is_store) begin
                        s = st >> (8 * k);
                        chk("acc_mc_dout", {24'd0, mc_dout_o}, {24'd0, s[7:0]});
                    end
                    if (mc_ack_i && rdy) begin
                        if (is_store) begin
                            s = st >> (8 * k);
                            mem[a[7:0]] = s[7:0];
                        end
                        k++;
                        if (k == n) phase = 2;
                    end
                end
                default: begin
                    chk("done_stall", {31'd0, stall_req_o}, 32'd0);
                    chk("done_mc_req", {31'd0, mc_req_o}, 32'd0);
                    chk("done_w_addr", {27'd0, w_addr_o}, {27'd0, waddr});
                    chk("done_w_req", {31'd0, w_req_o}, {31'd0, wreq & ~is_store});
                    chk("done_w_data", w_data_o, exp_w);
                    got_data = w_data_o;
                    if (rdy) done = 1;
                end
            endcase
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got phase %0d byte %0d expected completion", phase, k);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] bytes_le;
        logic [31:0] exp_data;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] got, a, mask;
        int cyc;

        vecs[0] = '{4'd3, 32'h0000_0100, 32'h0, 32'h1234_5678, 32'h1234_5678, 6};
        vecs[1] = '{4'd1, 32'h0000_0020, 32'h0, 32'h0000_0080, 32'hFFFF_FF80, 3};
        vecs[2] = '{4'd4, 32'h0000_0020, 32'h0, 32'h0000_0080, 32'h0000_0080, 3};
        vecs[3] = '{4'd2, 32'h0000_0030, 32'h0, 32'h0000_8000, 32'hFFFF_8000, 4};
        vecs[4] = '{4'd5, 32'h0000_0030, 32'h0, 32'h0000_8000, 32'h0000_8000, 4};
        vecs[5] = '{4'd8, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0, 32'h0, 6};
        vecs[6] = '{4'd6, 32'h0000_0050, 32'h1122_3344, 32'h0, 32'h0, 3};

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        rst = 1'b1; rdy = 1'b1; mc_ack_i = 1'b0;
        set_inputs(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mc_req", {31'd0, mc_req_o}, 32'd0);
        chk("rst_mc_we", {31'd0, mc_we_o}, 32'd0);
        chk("rst_mc_addr", mc_addr_o, 32'd0);
        chk("rst_mc_dout", {24'd0, mc_dout_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);

        do_nonmem(4'd0, 5'd5, 1'b1, 32'h1234_5678);

        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < 4; b++) begin
                a = vecs[i].addr + b;
                mem[a[7:0]] = vecs[i].bytes_le[8*b +: 8];
            end
            do_op(vecs[i].op, vecs[i].addr, vecs[i].st, 5'(i + 7), 1'b1, $urandom,
                  100, 100, 0, -1, got, cyc);
            chk("vec_data", got, vecs[i].exp_data);
            chk("vec_latency", cyc, vecs[i].exp_cycles);
            if (vecs[i].op >= 4'd6) begin
                mask = (nbytes(vecs[i].op) == 4) ? 32'hFFFF_FFFF :
                       (nbytes(vecs[i].op) == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
                chk("vec_mem", mem_word(vecs[i].addr) & mask, vecs[i].st & mask);
            end
        end

        // Reset in the middle of an LW, with an ack in the reset cycle.
        @(negedge clk);
        rdy = 1'b1; rst = 1'b0; mc_ack_i = 1'b0;
        set_inputs(4'd3, 32'h40, 32'd0, 5'd3, 1'b1, 32'd0);
        #1 chk("rstmid_stall0", {31'd0, stall_req_o}, 32'd1);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mc_ack_i = 1'b1;
            #1 chk("rstmid_addr", mc_addr_o, 32'h40 + b);
        end
        @(negedge clk);
        rst = 1'b1; mc_ack_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_inputs(4'd0, 32'h40, 32'd0, 5'd9, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("rstmid_stall", {31'd0, stall_req_o}, 32'd0);
        chk("rstmid_mc_req", {31'd0, mc_req_o}, 32'd0);
        chk("rstmid_mc_addr", mc_addr_o, 32'd0);
        chk("rstmid_w_data", w_data_o, 32'hDEAD_BEEF);
        chk("rstmid_w_addr", {27'd0, w_addr_o}, 32'd9);
        mc_ack_i = 1'b0;
        do_op(4'd3, 32'h40, 32'd0, 5'd3, 1'b1, 32'd0, 100, 100, 0, -1, got, cyc);
        chk("rstmid_relw", got, mem_word(32'h40));

        // SH across a 1 KiB boundary with byte 0 ack withheld for 3 cycles.
        do_op(4'd7, 32'h3FF, 32'hAABB_CCDD, 5'd4, 1'b1, 32'h5, 100, 100, 3, -1, got, cyc);
        chk("sh_latency", cyc, 7);
        chk("sh_mem", mem_word(32'h3FF) & 32'hFFFF, 32'hCCDD);

        // LW with rdy low for 2 cycles while byte 2 is outstanding.
        for (int b = 0; b < 4; b++) mem[8'h80 + b] = 8'(8'hA0 + b);
        do_op(4'd3, 32'h180, 32'd0, 5'd6, 1'b1, 32'd0, 100, 100, 0, 2, got, cyc);
        chk("lw_rdy_data", got, 32'hA3A2_A1A0);
        chk("lw_rdy_latency", cyc, 8);

        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(15));
            if (op >= 4'd1 && op <= 4'd8) begin
                do_op(op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                      70, 80, 0, -1, got, cyc);
            end else begin
                do_nonmem(op, 5'($urandom), 1'($urandom), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the five-stage pipeline. Sits after the EX/MEM pipeline register and feeds the MEM/WB register.
- Non-memory instructions pass straight through.
- Loads and stores are sequenced as byte-serial transfers to the memory controller, with a stall request held until the access completes.
- Handles LB/LH/LW/LBU/LHU/SB/SH/SW, little-endian.

Parameters:
- None. Widths are fixed: data 32, register address 5, memory byte 8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset, sampled on posedge clk
- rdy  in  1  global ready; when low, all state is frozen
- mem_op_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- w_addr_i  in  5  destination register
- w_req_i  in  1  register write request
- w_data_i  in  32  ALU result (non-load write data)
- mem_addr_i  in  32  effective byte address
- st_data_i  in  32  store data
- w_addr_o  out  5  to MEM/WB
- w_req_o  out  1  to MEM/WB
- w_data_o  out  32  to MEM/WB
- stall_req_o  out  1  stall request to the stall controller
- mc_req_o  out  1  byte request to the memory controller
- mc_we_o  out  1  1 = write byte
- mc_addr_o  out  32  byte address
- mc_dout_o  out  8  write byte
- mc_din_i  in  8  read byte, valid in the same cycle as mc_ack_i
- mc_ack_i  in  1  byte transfer completed this cycle

Behaviour:
- State machine: IDLE, ACCESS, DONE. Registers:
  - byte counter cnt (2 bits)
  - assembly buffer buf (32 bits)
- Byte count per op: N = 1 for B, 2 for H, 4 for W.
- Reset (rst=1 at posedge with rdy=1):
  - state IDLE, cnt 0, buf 0.
  - Resulting outputs: mc_req_o 0, mc_we_o 0, mc_addr_o 0, mc_dout_o 0, stall_req_o 0.
  - Reset mid-transfer abandons the access; any ack arriving in the reset cycle is ignored.
- rdy=0: state, cnt and buf hold. Combinational outputs still follow the current state.
- IDLE:
  - op NONE: outputs = inputs (w_*_o = w_*_i), stall_req_o 0, mc_req_o 0.
  - op load/store: stall_req_o 1 combinationally in this same cycle; next state ACCESS; cnt 0.
  - Upstream holds all *_i inputs stable while stall_req_o is high.
- ACCESS:
  - stall_req_o 1, mc_req_o 1, mc_addr_o = mem_addr_i + cnt (32-bit wrap).
  - mc_we_o 1 for stores; mc_dout_o = st_data_i[8*cnt+7 : 8*cnt].
  - On mc_ack_i:
    - loads capture buf[8*cnt+7 : 8*cnt] = mc_din_i.
    - if cnt == N-1, go to DONE; otherwise cnt increments.
  - Without an ack, address and data stay stable. mc_req_o never drops inside ACCESS.
  - Minimum ACCESS length is N cycles (ack every cycle).
  - No alignment requirement: bytes go to consecutive addresses, including across 0xFFFFFFFF -> 0.
- DONE (exactly one cycle):
  - stall_req_o 0, mc_req_o 0.
  - Load write data:
    - LB: sign-extend buf[7:0]; LBU: zero-extend buf[7:0].
    - LH: sign-extend buf[15:0]; LHU: zero-extend buf[15:0].
    - LW: buf.
  - For loads, w_req_o = w_req_i. Stores drive w_req_o 0, w_data_o 0 and w_addr_o = w_addr_i.
  - Next state IDLE, buf cleared. MEM/WB latches the result at the end of the DONE cycle.
- Total latency for a load/store with ack every cycle: N+2 cycles from op presentation to the MEM/WB latch.
- An ack while not in ACCESS is ignored.
- Writes to register x0 are passed through unchanged; suppression happens at writeback.

Test Plan:
- Reset during ACCESS of an LW (after 2 acks) -> next cycle: state IDLE, mc_req_o 0, stall_req_o 0, buf 0. A following NONE op passes through unchanged.
- NONE op, w_addr_i 5, w_req_i 1, w_data_i 0x12345678 -> same-cycle w_*_o match the inputs; stall_req_o 0, mc_req_o 0.
- LW at 0x100, ack every cycle, bytes 0x78, 0x56, 0x34, 0x12:
  - mc_addr_o steps 0x100..0x103.
  - stall_req_o high for 5 cycles; in DONE, w_data_o = 0x12345678.
- LB at 0x20 reading 0x80 -> 0xFFFFFF80. LBU at the same address -> 0x00000080. LH over bytes 0x00, 0x80 -> 0xFFFF8000.
- SH of st_data_i 0xAABBCCDD at 0x3FF, ack withheld 3 cycles on byte 0:
  - byte 0 (addr 0x3FF, 0xDD) is held stable until its ack, then byte 1 (addr 0x400, 0xCC) goes out.
  - mc_we_o 1 throughout; in DONE, w_req_o 0.
- LW with rdy held low for 2 cycles mid-ACCESS -> cnt and buf are frozen, no byte is skipped or duplicated, and the final data is correct.
